// File: rtl/scoreboard_pkg.sv
// Shared types and width helpers for the scoreboard issue controller.
package scoreboard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Index width for a memory of the given depth (never narrower than 1 bit).
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width able to hold every value 0..max_count.
  function automatic int unsigned count_width(input int unsigned max_count);
    return (max_count > 0) ? $clog2(max_count + 1) : 1;
  endfunction

endpackage

// File: rtl/pend_counter_array.sv
// Per-address pending-write counters with one increment and one decrement
// port. A decrement aimed at a zero counter is ignored and flagged.
module pend_counter_array #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6,
  parameter int unsigned CW    = 3
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_inc_en,
  input  logic [AW-1:0] i_inc_addr,
  input  logic          i_dec_en,
  input  logic [AW-1:0] i_dec_addr,
  input  logic [AW-1:0] i_rd1_addr,
  input  logic [AW-1:0] i_rd2_addr,
  input  logic [AW-1:0] i_rd3_addr,
  output logic [CW-1:0] o_rd1_cnt,
  output logic [CW-1:0] o_rd2_cnt,
  output logic [CW-1:0] o_rd3_cnt,
  output logic          o_underflow
);

  logic [CW-1:0] r_pend [DEPTH];

  // Read ports and underflow detection on the registered counts.
  always_comb begin
    o_rd1_cnt   = r_pend[i_rd1_addr];
    o_rd2_cnt   = r_pend[i_rd2_addr];
    o_rd3_cnt   = r_pend[i_rd3_addr];
    o_underflow = i_dec_en && (r_pend[i_dec_addr] == '0);
  end

  // Counter update; same-entry increment and decrement cancel out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_pend[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (i_inc_en && (i_inc_addr == AW'(i)) &&
            !(i_dec_en && (i_dec_addr == AW'(i)) && (r_pend[i] != '0)))
          r_pend[i] <= r_pend[i] + CW'(1);
        else if (!(i_inc_en && (i_inc_addr == AW'(i))) &&
                 i_dec_en && (i_dec_addr == AW'(i)) && (r_pend[i] != '0))
          r_pend[i] <= r_pend[i] - CW'(1);
      end
    end
  end

endmodule

// File: rtl/scoreboard_issue_ctrl.sv
// Issue controller: accepts decoded instructions from fetch, stalls on
// RAW (optionally WAW) hazards against a pending-write scoreboard, bounds
// the number of outstanding instructions and signals program completion.
module scoreboard_issue_ctrl
  import scoreboard_pkg::*;
#(
  parameter int unsigned INS_MEM_SIZE  = 32,
  parameter int unsigned DATA_MEM_SIZE = 64,
  parameter int unsigned OP_WIDTH      = 3,
  parameter int unsigned MAX_INFLIGHT  = 4,
  parameter bit          WAW_STALL     = 1'b0,
  localparam int unsigned PC_W = addr_width(INS_MEM_SIZE),
  localparam int unsigned AW   = addr_width(DATA_MEM_SIZE),
  localparam int unsigned CW   = count_width(MAX_INFLIGHT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_valid,
  input  logic [OP_WIDTH-1:0] fetch_opcode,
  input  logic [AW-1:0]       fetch_src1,
  input  logic [AW-1:0]       fetch_src2,
  input  logic [AW-1:0]       fetch_dst,
  input  logic                fetch_last,
  output logic                fetch_ready,
  output logic [PC_W-1:0]     pc,
  output logic                issue_valid,
  output logic [OP_WIDTH-1:0] issue_opcode,
  output logic [AW-1:0]       issue_src1,
  output logic [AW-1:0]       issue_src2,
  output logic [AW-1:0]       issue_dst,
  input  logic                issue_ready,
  input  logic                retire_valid,
  input  logic [AW-1:0]       retire_addr,
  output logic [CW-1:0]       inflight,
  output logic                executed,
  output logic                error
);

  state_t              r_state, w_state_next;
  logic [PC_W-1:0]     r_pc;
  logic [CW-1:0]       r_inflight;
  logic                r_issue_valid;
  logic [OP_WIDTH-1:0] r_issue_opcode;
  logic [AW-1:0]       r_issue_src1, r_issue_src2, r_issue_dst;
  logic                r_error, r_executed;

  logic [CW-1:0]       w_cnt_src1, w_cnt_src2, w_cnt_dst;
  logic                w_underflow, w_hazard, w_slot_free, w_room;
  logic                w_accept, w_retire_ok;

  pend_counter_array #(
    .DEPTH (DATA_MEM_SIZE),
    .AW    (AW),
    .CW    (CW)
  ) u_pend (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_inc_en    (w_accept),
    .i_inc_addr  (fetch_dst),
    .i_dec_en    (retire_valid),
    .i_dec_addr  (retire_addr),
    .i_rd1_addr  (fetch_src1),
    .i_rd2_addr  (fetch_src2),
    .i_rd3_addr  (fetch_dst),
    .o_rd1_cnt   (w_cnt_src1),
    .o_rd2_cnt   (w_cnt_src2),
    .o_rd3_cnt   (w_cnt_dst),
    .o_underflow (w_underflow)
  );

  // Acceptance decision; hazards use registered counts only (no retire bypass).
  always_comb begin
    w_hazard    = (w_cnt_src1 != '0) || (w_cnt_src2 != '0) ||
                  (WAW_STALL && (w_cnt_dst != '0));
    w_slot_free = !r_issue_valid || issue_ready;
    w_room      = (r_inflight < CW'(MAX_INFLIGHT));
    w_accept    = (r_state == RUN) && fetch_valid && !w_hazard && w_room && w_slot_free;
    w_retire_ok = retire_valid && !w_underflow;
  end

  // Next-state logic: RUN until the last instruction issues, then drain.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (w_accept && fetch_last) w_state_next = DRAIN;
      DRAIN:   if ((r_inflight == '0) && !r_issue_valid) w_state_next = DONE;
      DONE:    w_state_next = DONE;
      default: w_state_next = RUN;
    endcase
  end

  // State register and completion flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= RUN;
      r_executed <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_executed <= (w_state_next == DONE);
    end
  end

  // Issue register, program counter, outstanding count and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc           <= '0;
      r_inflight     <= '0;
      r_issue_valid  <= 1'b0;
      r_issue_opcode <= '0;
      r_issue_src1   <= '0;
      r_issue_src2   <= '0;
      r_issue_dst    <= '0;
      r_error        <= 1'b0;
    end else begin
      if (w_accept) begin
        r_issue_valid  <= 1'b1;
        r_issue_opcode <= fetch_opcode;
        r_issue_src1   <= fetch_src1;
        r_issue_src2   <= fetch_src2;
        r_issue_dst    <= fetch_dst;
        r_pc           <= r_pc + PC_W'(1);
      end else if (issue_ready) begin
        r_issue_valid  <= 1'b0;
      end
      case ({w_accept, w_retire_ok})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
      if (retire_valid && w_underflow) r_error <= 1'b1;
    end
  end

  always_comb begin
    fetch_ready  = w_accept;
    pc           = r_pc;
    issue_valid  = r_issue_valid;
    issue_opcode = r_issue_opcode;
    issue_src1   = r_issue_src1;
    issue_src2   = r_issue_src2;
    issue_dst    = r_issue_dst;
    inflight     = r_inflight;
    executed     = r_executed;
    error        = r_error;
  end

endmodule

// File: tb/tb_scoreboard_issue_ctrl.sv
// Scoreboard bench for scoreboard_issue_ctrl: accepted instructions are
// queued as expectations and a monitor compares each issue handshake.
module tb_scoreboard_issue_ctrl;

  logic       clk, rst_n;
  // main DUT (WAW_STALL=0)
  logic       fv, flast, fready;
  logic [2:0] fop;
  logic [5:0] fs1, fs2, fd;
  logic [4:0] pc;
  logic       iv, executed, error;
  logic [2:0] iop;
  logic [5:0] is1, is2, idst;
  logic [2:0] inflight;
  // shared pipeline-side inputs
  logic       iready, rv;
  logic [5:0] raddr;
  // second DUT (WAW_STALL=1)
  logic       wfv, wflast, wfready;
  logic [2:0] wfop;
  logic [5:0] wfs1, wfs2, wfd;
  logic [4:0] w_pc;
  logic       w_iv, w_exec, w_err;
  logic [2:0] w_iop;
  logic [5:0] w_is1, w_is2, w_idst;
  logic [2:0] w_inflight;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_acc    = 0;
  int unsigned w;
  logic [20:0] exp_q[$];
  logic [20:0] mon_e;

  scoreboard_issue_ctrl u_dut (
    .clk(clk), .reset(rst_n),
    .fetch_valid(fv), .fetch_opcode(fop), .fetch_src1(fs1), .fetch_src2(fs2),
    .fetch_dst(fd), .fetch_last(flast), .fetch_ready(fready), .pc(pc),
    .issue_valid(iv), .issue_opcode(iop), .issue_src1(is1), .issue_src2(is2),
    .issue_dst(idst), .issue_ready(iready), .retire_valid(rv), .retire_addr(raddr),
    .inflight(inflight), .executed(executed), .error(error)
  );

  scoreboard_issue_ctrl #(.WAW_STALL(1'b1)) u_dut_waw (
    .clk(clk), .reset(rst_n),
    .fetch_valid(wfv), .fetch_opcode(wfop), .fetch_src1(wfs1), .fetch_src2(wfs2),
    .fetch_dst(wfd), .fetch_last(wflast), .fetch_ready(wfready), .pc(w_pc),
    .issue_valid(w_iv), .issue_opcode(w_iop), .issue_src1(w_is1), .issue_src2(w_is2),
    .issue_dst(w_idst), .issue_ready(iready), .retire_valid(rv), .retire_addr(raddr),
    .inflight(w_inflight), .executed(w_exec), .error(w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_fetch(input logic [2:0] op, input logic [5:0] s1, input logic [5:0] s2,
                           input logic [5:0] d, input logic last);
    fop = op; fs1 = s1; fs2 = s2; fd = d; flast = last; fv = 1'b1;
  endtask

  task automatic push_cur();
    exp_q.push_back({fop, fs1, fs2, fd});
    n_acc++;
  endtask

  // Present one instruction and hold it until accepted (bounded wait).
  task automatic accept_one(input logic [2:0] op, input logic [5:0] s1, input logic [5:0] s2,
                            input logic [5:0] d, input logic last, output int unsigned waits);
    set_fetch(op, s1, s2, d, last);
    waits = 0;
    @(negedge clk);
    while (!fready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (fready) push_cur();
    else check("accept_timeout", 32'(fready), 32'd1);
    tick();
    fv = 1'b0;
  endtask

  task automatic retire(input logic [5:0] a);
    rv = 1'b1; raddr = a;
    tick();
    rv = 1'b0;
  endtask

  // Monitor: every issue handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && iv && iready) begin
      if (exp_q.size() == 0) begin
        check("issue_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_fields", 32'({iop, is1, is2, idst}), 32'(mon_e));
      end
    end
  end

  initial begin
    rst_n = 1'b0; iready = 1'b1; rv = 1'b0; raddr = '0;
    fv = 1'b0; fop = '0; fs1 = '0; fs2 = '0; fd = '0; flast = 1'b0;
    wfv = 1'b0; wfop = '0; wfs1 = '0; wfs2 = '0; wfd = '0; wflast = 1'b0;
    #12;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_inflight", 32'(inflight), 32'd0);
    check("rst_issue_valid", 32'(iv), 32'd0);
    check("rst_issue_dst", 32'(idst), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_executed", 32'(executed), 32'd0);
    tick();
    rst_n = 1'b1;

    // Independent stream, one accept per cycle
    for (int unsigned k = 0; k < 3; k++) begin
      accept_one(3'd1, 6'd0, 6'd1, 6'(5 + k), 1'b0, w);
      check("stream_wait", w, 32'd0);
      check("stream_pc", 32'(pc), k + 1);
    end
    check("stream_inflight", 32'(inflight), 32'd3);
    check("stream_last_dst", 32'(idst), 32'd7);
    for (int unsigned k = 0; k < 3; k++) retire(6'(5 + k));
    check("stream_drained", 32'(inflight), 32'd0);

    // RAW stall released one cycle after the retire
    accept_one(3'd2, 6'd0, 6'd1, 6'd5, 1'b0, w);
    set_fetch(3'd2, 6'd5, 6'd2, 6'd8, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("raw_stall", 32'(fready), 32'd0);
    end
    tick();
    rv = 1'b1; raddr = 6'd5;
    @(negedge clk);
    check("raw_no_bypass", 32'(fready), 32'd0);
    tick();
    rv = 1'b0;
    @(negedge clk);
    check("raw_accept_after_retire", 32'(fready), 32'd1);
    if (fready) push_cur();
    tick();
    fv = 1'b0;
    retire(6'd8);
    check("raw_inflight", 32'(inflight), 32'd0);
    check("raw_pc", 32'(pc), 32'(n_acc % 32));

    // Capacity limit (sources 5 also confirm pend[5] returned to 0)
    for (int unsigned k = 0; k < 4; k++) begin
      accept_one(3'd3, 6'd5, 6'd5, 6'(10 + k), 1'b0, w);
      check("cap_wait", w, 32'd0);
    end
    check("cap_inflight_full", 32'(inflight), 32'd4);
    set_fetch(3'd3, 6'd0, 6'd1, 6'd14, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("cap_stall", 32'(fready), 32'd0);
    end
    tick();
    rv = 1'b1; raddr = 6'd10;
    @(negedge clk);
    check("cap_no_bypass", 32'(fready), 32'd0);
    tick();
    rv = 1'b0;
    @(negedge clk);
    check("cap_accept_after_retire", 32'(fready), 32'd1);
    if (fready) push_cur();
    tick();
    fv = 1'b0;
    for (int unsigned k = 1; k < 5; k++) retire(6'(10 + k));
    check("cap_inflight_empty", 32'(inflight), 32'd0);

    // Backpressure holds the issue register and pc
    iready = 1'b0;
    accept_one(3'd4, 6'd0, 6'd1, 6'd20, 1'b0, w);
    set_fetch(3'd5, 6'd0, 6'd1, 6'd21, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check("bp_ready_low", 32'(fready), 32'd0);
      check("bp_hold", 32'({iv, iop, idst}), 32'({1'b1, 3'd4, 6'd20}));
      check("bp_pc_held", 32'(pc), 32'(n_acc % 32));
    end
    tick();
    iready = 1'b1;
    @(negedge clk);
    check("bp_release_accept", 32'(fready), 32'd1);
    if (fready) push_cur();
    tick();
    fv = 1'b0;
    retire(6'd20);
    retire(6'd21);
    check("bp_inflight", 32'(inflight), 32'd0);
    check("queue_empty_1", exp_q.size(), 32'd0);

    // WAW: fresh start for both instances
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    n_acc = 0;
    set_fetch(3'd1, 6'd0, 6'd1, 6'd9, 1'b0);
    wfop = 3'd1; wfs1 = 6'd0; wfs2 = 6'd1; wfd = 6'd9; wfv = 1'b1;
    @(negedge clk);
    check("waw_first_main", 32'(fready), 32'd1);
    check("waw_first_stall", 32'(wfready), 32'd1);
    if (fready) push_cur();
    tick();
    set_fetch(3'd1, 6'd2, 6'd3, 6'd9, 1'b0);
    wfs1 = 6'd2; wfs2 = 6'd3;
    @(negedge clk);
    check("waw0_second_accept", 32'(fready), 32'd1);
    check("waw1_second_stall", 32'(wfready), 32'd0);
    if (fready) push_cur();
    tick();
    set_fetch(3'd2, 6'd9, 6'd0, 6'd15, 1'b0);
    @(negedge clk);
    check("waw0_raw9_stall", 32'(fready), 32'd0);
    check("waw1_stall_c", 32'(wfready), 32'd0);
    check("waw0_inflight", 32'(inflight), 32'd2);
    tick();
    rv = 1'b1; raddr = 6'd9;
    @(negedge clk);
    check("waw1_no_bypass", 32'(wfready), 32'd0);
    tick();
    rv = 1'b0;
    @(negedge clk);
    check("waw0_pend9_was_two", 32'(fready), 32'd0);
    check("waw1_accept_after_retire", 32'(wfready), 32'd1);
    tick();
    wfv = 1'b0;
    rv = 1'b1; raddr = 6'd9;
    @(negedge clk);
    check("waw0_stall_f", 32'(fready), 32'd0);
    tick();
    rv = 1'b0;
    @(negedge clk);
    check("waw0_accept_z", 32'(fready), 32'd1);
    if (fready) push_cur();
    tick();
    fv = 1'b0;
    retire(6'd15);
    check("waw0_inflight_end", 32'(inflight), 32'd0);
    check("waw0_error", 32'(error), 32'd0);
    check("waw1_inflight_end", 32'(w_inflight), 32'd0);

    // Drain to completion
    accept_one(3'd6, 6'd0, 6'd1, 6'd30, 1'b1, w);
    set_fetch(3'd6, 6'd0, 6'd1, 6'd31, 1'b0);
    @(negedge clk);
    check("drain_blocks", 32'(fready), 32'd0);
    check("drain_not_exec", 32'(executed), 32'd0);
    tick();
    fv = 1'b0;
    rv = 1'b1; raddr = 6'd30;
    @(negedge clk);
    check("drain_inflight_one", 32'(inflight), 32'd1);
    tick();
    rv = 1'b0;
    @(negedge clk);
    check("drain_inflight_zero", 32'(inflight), 32'd0);
    check("exec_registered", 32'(executed), 32'd0);
    tick();
    fv = 1'b1;
    @(negedge clk);
    check("executed", 32'(executed), 32'd1);
    check("done_blocks", 32'(fready), 32'd0);
    check("done_pc", 32'(pc), 32'(n_acc % 32));
    fv = 1'b0;
    check("pre_spurious_error", 32'(error), 32'd0);
    tick();
    retire(6'd40);
    check("spurious_error", 32'(error), 32'd1);
    check("spurious_inflight", 32'(inflight), 32'd0);
    check("queue_empty_2", exp_q.size(), 32'd0);

    // Asynchronous reset in the middle of DRAIN
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_acc = 0;
    iready = 1'b0;
    accept_one(3'd7, 6'd3, 6'd4, 6'd2, 1'b1, w);
    @(negedge clk);
    check("mid_pre_valid", 32'({iv, inflight, pc}), 32'({1'b1, 3'd1, 5'd1}));
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc", 32'(pc), 32'd0);
    check("mid_rst_inflight", 32'(inflight), 32'd0);
    check("mid_rst_issue", 32'({iv, iop, is1, is2, idst}), 32'd0);
    check("mid_rst_flags", 32'({executed, error}), 32'd0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    iready = 1'b1;
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/scoreboard_issue_ctrl.md
Name: scoreboard_issue_ctrl

Overview:
- Parametrised successor to the fetch/load/execute/save sequencing controller.
- Sits between the fetch stage and the load/execute/save pipeline, with a per-address pending-write scoreboard.
- Issues decoded instructions over a valid/ready handshake and stalls on RAW (and optionally WAW) hazards.
- Allows up to MAX_INFLIGHT outstanding instructions and raises executed once the program has fully drained.

Parameters:
- INS_MEM_SIZE, 32, instruction memory depth; PC_W = $clog2(INS_MEM_SIZE)
- DATA_MEM_SIZE, 64, data memory depth; AW = $clog2(DATA_MEM_SIZE)
- OP_WIDTH, 3, opcode width
- MAX_INFLIGHT, 4, max issued-but-unretired instructions; CW = $clog2(MAX_INFLIGHT+1)
- WAW_STALL, 0, 1 = also stall when the destination has a pending write

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- fetch_valid  in  1  decoded instruction present
- fetch_opcode  in  OP_WIDTH  opcode
- fetch_src1  in  AW  source 1 address
- fetch_src2  in  AW  source 2 address
- fetch_dst  in  AW  destination address
- fetch_last  in  1  this instruction is the final one of the program
- fetch_ready  out  1  instruction accepted this cycle (combinational)
- pc  out  PC_W  next instruction address to fetch
- issue_valid  out  1  registered instruction for the load stage
- issue_opcode  out  OP_WIDTH  registered opcode
- issue_src1  out  AW  registered source 1 address
- issue_src2  out  AW  registered source 2 address
- issue_dst  out  AW  registered destination address
- issue_ready  in  1  load stage takes the instruction
- retire_valid  in  1  save stage completed a write
- retire_addr  in  AW  address written
- inflight  out  CW  outstanding instruction count
- executed  out  1  program complete and pipeline drained
- error  out  1  sticky: retire arrived for an address with zero pending count

Behaviour:
- Reset (reset=0, asynchronous) clears:
  - pc, all pend[], inflight, issue_* outputs, error and executed to 0;
  - FSM to RUN.
  - Reset mid-operation discards in-flight tracking.
- Scoreboard: pend[a], CW bits, one counter per data address, DATA_MEM_SIZE entries.
- hazard = pend[fetch_src1]!=0 | pend[fetch_src2]!=0 | (WAW_STALL & pend[fetch_dst]!=0).
  - Evaluated on registered counts only; there is no retire bypass.
  - A retire that clears a hazard permits acceptance in the following cycle, not the same one.
- slot_free = !issue_valid | issue_ready.
- fetch_ready = (state==RUN) & fetch_valid & !hazard & (inflight<MAX_INFLIGHT) & slot_free.
- Accept (fetch_ready=1), effects visible next edge (latency 1):
  - issue_* <= fetch fields, issue_valid <= 1;
  - pend[fetch_dst]++, inflight++;
  - pc <= pc+1, wrapping modulo 2^PC_W.
- If issue_ready=1 and there is no accept, issue_valid <= 0.
- issue_* hold stable while issue_valid & !issue_ready.
- Retire (retire_valid=1):
  - if pend[retire_addr]!=0, decrement it and inflight;
  - otherwise set error, leave counters unchanged.
- Simultaneous accept and retire:
  - each counter update nets to +1, -1 or 0;
  - same-address increment and decrement gives a net 0 change;
  - inflight uses the same rule.
- Counters never exceed MAX_INFLIGHT, guaranteed by the inflight check.
- FSM:
  - RUN: an accept with fetch_last=1 goes to DRAIN.
  - DRAIN: fetch_ready=0; when inflight==0 and issue_valid==0, go to DONE.
  - DONE: executed=1; fetch_ready=0; stays until reset.
- executed is registered and asserts the cycle after the DRAIN exit condition holds.

Decomposition:
- Package scoreboard_pkg:
  - state enum {RUN, DRAIN, DONE};
  - width helper functions for AW, PC_W, CW.
- Sub-module pend_counter_array:
  - DATA_MEM_SIZE x CW counters;
  - one increment port, one decrement port;
  - two read ports plus a dst read port;
  - underflow flag output.

Test Plan:
- Independent stream: dst 5,6,7 with sources 0/1, issue_ready=1 → one accept per cycle; pc 0→3; inflight reaches 3; issue_dst 5,6,7 on consecutive cycles.
- RAW stall: instr A dst=5, then B src1=5 → fetch_ready=0 until retire_addr=5. B is accepted exactly 1 cycle after the retire; pend[5] goes 1→0→0.
- Capacity: MAX_INFLIGHT=4, 5 independent instructions, no retires → 4 accepted, fifth stalled with inflight=4. One retire → fifth accepted next cycle.
- Backpressure: issue_ready=0 for 3 cycles with issue_valid=1 → issue_* unchanged, fetch_ready=0, pc held. Release → next instruction accepted.
- WAW_STALL=1: two instructions with dst=9 → second stalls until retire 9. With WAW_STALL=0, pend[9] reaches 2.
- Drain and error:
  - last instruction accepted → DRAIN; final retire → executed=1 one cycle after inflight=0.
  - a spurious retire to an address with zero count sets error=1.
  - mid-DRAIN reset=0 → all outputs 0 asynchronously.
